pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage in-order core. It combines the load-use stall flag, the EX-stage branch/jump redirect and the instruction/data memory handshakes. From these it drives per-stage pipeline-register write enables, bubble-insert (flush) controls and PC update. It also tracks multi-cycle data-memory waits with a timeout watchdog that halts the core on a hung access.

---
 rtl/pipeline_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer with MEM-wait watchdog; optional perf counters under PIPELINE_CTRL_PERF_EN
module pipeline_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_stall,
    input  logic             ex_redirect,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_sel_redirect,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             mem_wait,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] MAX_W = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           mem_stall;

    // Once in MEM_WAIT the access is pending regardless of dmem_req.
    assign mem_stall = (state == RUN && dmem_req && !dmem_ready) ||
                       (state == MEM_WAIT && !dmem_ready);

    assign mem_wait    = (state == MEM_WAIT);
    assign mem_timeout = (state == HALT);

    always_comb begin
        pc_write        = 1'b0;
        pc_sel_redirect = 1'b0;
        if_id_write     = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_write     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_write    = 1'b0;
        mem_wb_flush    = 1'b0;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state == HALT) begin
            pc_write = 1'b0;
        end else if (mem_stall) begin
            mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
            pc_write        = 1'b1;
            pc_sel_redirect = 1'b1;
            if_id_write     = 1'b1;
            if_id_flush     = 1'b1;
            id_ex_write     = 1'b1;
            id_ex_flush     = 1'b1;
            ex_mem_write    = 1'b1;
        end else if (load_use_stall) begin
            id_ex_write  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b1;
        end else if (!imem_ready) begin
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
        end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (MAX_WAIT != 0 && wait_cnt == MAX_W)
                            state <= HALT;
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic row_redirect;
    assign row_redirect = (state != HALT) && !mem_stall && ex_redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else if (state != HALT) begin
            if (!pc_write && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
            if (row_redirect && !(&redirect_count))
                redirect_count <= redirect_count + 1'b1;
        end
    end
`else
    assign stall_cycles   = '0;
    assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - randomized bench for pipeline_ctrl against a behavioural reference model
module tb_pipeline_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, load_use_stall, ex_redirect, imem_ready, dmem_req, dmem_ready;
    logic pc_write, pc_sel_redirect, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic ex_mem_write, mem_wb_flush, mem_wait, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, redirect_count;

    pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .load_use_stall(load_use_stall), .ex_redirect(ex_redirect),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .pc_sel_redirect(pc_sel_redirect),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .mem_wb_flush(mem_wb_flush),
        .mem_wait(mem_wait), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: an access is pending, the core has halted, length of the current stall run.
    bit m_pending, m_halted;
    int m_run, m_stalls, m_redirs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected vector: {pc_write, pc_sel, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f, mem_wait, mem_timeout}
    task automatic cycle(input bit r, input bit lus, input bit exr, input bit imr,
                         input bit dreq, input bit drdy, input string tag);
        logic [9:0] exp;
        bit stall, redir_row;
        rst = r; load_use_stall = lus; ex_redirect = exr;
        imem_ready = imr; dmem_req = dreq; dmem_ready = drdy;
        #3;
        stall     = !m_halted && (m_pending ? !drdy : (dreq && !drdy));
        redir_row = !r && !m_halted && !stall && exr;
        if (r)              exp[9:2] = 8'b0_0_0_1_0_1_0_1;
        else if (m_halted)  exp[9:2] = 8'b0;
        else if (stall)     exp[9:2] = 8'b0_0_0_0_0_0_0_1;
        else if (exr)       exp[9:2] = 8'b1_1_1_1_1_1_1_0;
        else if (lus)       exp[9:2] = 8'b0_0_0_0_1_1_1_0;
        else if (!imr)      exp[9:2] = 8'b0_0_1_1_1_0_1_0;
        else                exp[9:2] = 8'b1_0_1_0_1_0_1_0;
        exp[1] = m_pending && !m_halted;
        exp[0] = m_halted;
        check({tag, "/ctl"}, 32'({pc_write, pc_sel_redirect, if_id_write, if_id_flush,
                                  id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush,
                                  mem_wait, mem_timeout}), 32'(exp));
`ifdef PIPELINE_CTRL_PERF_EN
        check({tag, "/stall_cycles"}, 32'(stall_cycles), 32'(m_stalls));
        check({tag, "/redirect_count"}, 32'(redirect_count), 32'(m_redirs));
`else
        check({tag, "/stall_cycles"}, 32'(stall_cycles), 32'd0);
        check({tag, "/redirect_count"}, 32'(redirect_count), 32'd0);
`endif
        @(posedge clk);
        if (r) begin
            m_pending = 0; m_halted = 0; m_run = 0; m_stalls = 0; m_redirs = 0;
        end else if (!m_halted) begin
            if (!exp[9] && m_stalls < SAT) m_stalls++;
            if (redir_row && m_redirs < SAT) m_redirs++;
            if (stall) begin
                m_run++;
                if (MAX_WAIT != 0 && m_run == MAX_WAIT + 1) m_halted = 1;
                else m_pending = 1;
            end else begin
                m_run = 0;
                m_pending = 0;
            end
        end
        #1;
    endtask

    initial begin
        m_pending = 0; m_halted = 0; m_run = 0; m_stalls = 0; m_redirs = 0;
        rst = 1; load_use_stall = 1; ex_redirect = 0; imem_ready = 1; dmem_req = 0; dmem_ready = 0;
        @(posedge clk); #1;

        // Reset held with load-use pending, then idle run
        cycle(1, 1, 0, 1, 0, 0, "rst0");
        cycle(1, 1, 0, 1, 0, 0, "rst1");
        cycle(0, 0, 0, 1, 0, 0, "idle");
        // Load-use for one cycle, then normal
        cycle(0, 1, 0, 1, 0, 0, "lu");
        cycle(0, 0, 0, 1, 0, 0, "lu_after");
        // Redirect beats load-use and fetch miss
        cycle(0, 1, 1, 0, 0, 0, "redir_prio");
        cycle(0, 0, 0, 0, 0, 0, "imiss");
        // Three-cycle data wait with a redirect held in EX
        cycle(0, 0, 1, 1, 1, 0, "dw1");
        cycle(0, 0, 1, 1, 1, 0, "dw2");
        cycle(0, 0, 1, 1, 0, 0, "dw3_dropped_req");
        cycle(0, 0, 1, 1, 0, 1, "dw4_done");
        cycle(0, 0, 0, 1, 1, 1, "single_cycle_access");
        // Watchdog: data ready never arrives
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 1, 1, 0, $sformatf("hang%0d", i));
        cycle(1, 0, 0, 1, 0, 0, "hang_rst");
        cycle(0, 0, 0, 1, 0, 0, "hang_recovered");

        // Counter saturation and redirect count from a clean reset
        cycle(1, 0, 0, 1, 0, 0, "perf_rst");
        for (int i = 0; i < 20; i++) cycle(0, 1, 0, 1, 0, 0, $sformatf("perf_lu%0d", i));
        for (int i = 0; i < 3; i++)  cycle(0, 0, 1, 1, 0, 0, $sformatf("perf_rd%0d", i));
`ifdef PIPELINE_CTRL_PERF_EN
        check("perf_stall_sat", 32'(stall_cycles), 32'd15);
        check("perf_redir3", 32'(redirect_count), 32'd3);
`endif

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                  $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
